// File: rtl/peak_note_scheduler.sv
// peak_note_scheduler
// Collects the strongest FFT bins of a frame into a sorted peak table,
// resolves each peak to a note through an external note_lookup handshake,
// and publishes the frame's note bitmap with a one-cycle valid pulse.
// Optional feature macro: NOTE_TIMEOUT_EN (per-slot 64-cycle result timeout).
//
// Handshakes: a bin moves when bin_valid_in & bin_ready_out at a rising edge;
// a lookup request moves when lookup_valid_out & lookup_ready_in, and the
// request (valid and bin) stays stable until it moves; note_valid_in is a
// single-cycle result strobe that is only honoured in WAIT.
module peak_note_scheduler #(
   parameter int BIN_W     = 10,
   parameter int MAG_W     = 16,
   parameter int NUM_PEAKS = 4
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic [MAG_W-1:0] threshold_in,
   input  logic             bin_valid_in,
   input  logic [BIN_W-1:0] bin_index_in,
   input  logic [MAG_W-1:0] mag_in,
   input  logic             bin_last_in,
   output logic             bin_ready_out,
   output logic [BIN_W-1:0] lookup_bin_out,
   output logic             lookup_valid_out,
   input  logic             lookup_ready_in,
   input  logic             note_valid_in,
   input  logic [5:0]       note_index_in,
   output logic [63:0]      notes_out,
   output logic             notes_valid_out,
   output logic             busy_out,
   output logic             timeout_err_out,
   output logic [1:0]       state_dbg_out
);

   localparam int CNT_W = $clog2(NUM_PEAKS + 1);

   typedef enum logic [1:0] {ST_COLLECT, ST_DISPATCH, ST_WAIT, ST_PUBLISH} state_t;

   state_t           r_state;
   logic [BIN_W-1:0] r_tab_bin [NUM_PEAKS];
   logic [MAG_W-1:0] r_tab_mag [NUM_PEAKS];
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_k;
   logic [63:0]      r_bitmap;
   logic             r_bin_ready;
   logic             r_lookup_valid;
   logic [BIN_W-1:0] r_lookup_bin;
   logic [63:0]      r_notes;
   logic             r_notes_valid;
   logic             r_busy;

   logic             w_accept;
   logic             w_cand;
   logic [CNT_W-1:0] w_pos;
   logic             w_ins;
   logic [BIN_W-1:0] w_nxt_bin [NUM_PEAKS];
   logic [MAG_W-1:0] w_nxt_mag [NUM_PEAKS];
   logic [CNT_W-1:0] w_nxt_count;
   logic [CNT_W-1:0] w_k_inc;
   logic [BIN_W-1:0] w_k_bin;
   logic             w_timeout;

   assign w_accept = bin_valid_in & r_bin_ready;
   assign w_cand   = w_accept & (mag_in > threshold_in);
   assign w_k_inc  = r_k + CNT_W'(1);

   // Insertion slot: first empty slot or first entry strictly smaller than the
   // candidate, so equal magnitudes stay behind the earlier-accepted bin.
   always_comb begin
      w_pos = CNT_W'(NUM_PEAKS);
      for (int i = NUM_PEAKS - 1; i >= 0; i--) begin
         if ((CNT_W'(i) >= r_count) || (mag_in > r_tab_mag[i])) w_pos = CNT_W'(i);
      end
   end

   assign w_ins       = w_cand && (w_pos < CNT_W'(NUM_PEAKS));
   assign w_nxt_count = (w_ins && (r_count != CNT_W'(NUM_PEAKS))) ? r_count + CNT_W'(1) : r_count;

   // Next table contents: entries below the slot shift down one, the tail drops off.
   always_comb begin
      for (int i = 0; i < NUM_PEAKS; i++) begin
         w_nxt_bin[i] = r_tab_bin[i];
         w_nxt_mag[i] = r_tab_mag[i];
      end
      if (w_ins) begin
         for (int i = 1; i < NUM_PEAKS; i++) begin
            if (CNT_W'(i) > w_pos) begin
               w_nxt_bin[i] = r_tab_bin[i-1];
               w_nxt_mag[i] = r_tab_mag[i-1];
            end
         end
         for (int i = 0; i < NUM_PEAKS; i++) begin
            if (CNT_W'(i) == w_pos) begin
               w_nxt_bin[i] = bin_index_in;
               w_nxt_mag[i] = mag_in;
            end
         end
      end
   end

   // Bin of the slot after the current one, for the next request.
   always_comb begin
      w_k_bin = '0;
      for (int i = 0; i < NUM_PEAKS; i++) begin
         if (CNT_W'(i) == w_k_inc) w_k_bin = r_tab_bin[i];
      end
   end

`ifdef NOTE_TIMEOUT_EN
   logic [5:0] r_to_cnt;
   logic       r_timeout_err;

   assign w_timeout       = (r_state == ST_WAIT) && !note_valid_in && (r_to_cnt == 6'd63);
   assign timeout_err_out = r_timeout_err;

   // WAIT-cycle counter; the 64th silent WAIT cycle abandons the slot.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if ((r_state != ST_WAIT) || note_valid_in || w_timeout) r_to_cnt <= '0;
         else                                                    r_to_cnt <= r_to_cnt + 6'd1;
         if (w_timeout) r_timeout_err <= 1'b1;
      end
   end
`else
   assign w_timeout       = 1'b0;
   assign timeout_err_out = 1'b0;
`endif

   // Main FSM with all externally visible outputs registered.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_state        <= ST_COLLECT;
         for (int i = 0; i < NUM_PEAKS; i++) begin
            r_tab_bin[i] <= '0;
            r_tab_mag[i] <= '0;
         end
         r_count        <= '0;
         r_k            <= '0;
         r_bitmap       <= '0;
         r_bin_ready    <= 1'b0;
         r_lookup_valid <= 1'b0;
         r_lookup_bin   <= '0;
         r_notes        <= '0;
         r_notes_valid  <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_notes_valid <= 1'b0;
         case (r_state)
            ST_COLLECT: begin
               r_bin_ready <= 1'b1;
               r_busy      <= 1'b0;
               if (w_accept) begin
                  for (int i = 0; i < NUM_PEAKS; i++) begin
                     r_tab_bin[i] <= w_nxt_bin[i];
                     r_tab_mag[i] <= w_nxt_mag[i];
                  end
                  r_count <= w_nxt_count;
                  if (bin_last_in) begin
                     r_bin_ready <= 1'b0;
                     r_busy      <= 1'b1;
                     r_k         <= '0;
                     if (w_nxt_count == '0) begin
                        r_state <= ST_PUBLISH;
                     end else begin
                        r_state        <= ST_DISPATCH;
                        r_lookup_valid <= 1'b1;
                        r_lookup_bin   <= w_nxt_bin[0];
                     end
                  end
               end
            end
            ST_DISPATCH: begin
               if (lookup_ready_in) begin
                  r_lookup_valid <= 1'b0;
                  r_state        <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (note_valid_in) r_bitmap <= r_bitmap | (64'd1 << note_index_in);
               if (note_valid_in || w_timeout) begin
                  r_k <= w_k_inc;
                  if (w_k_inc < r_count) begin
                     r_state        <= ST_DISPATCH;
                     r_lookup_valid <= 1'b1;
                     r_lookup_bin   <= w_k_bin;
                  end else begin
                     r_state <= ST_PUBLISH;
                  end
               end
            end
            default: begin
               r_notes       <= r_bitmap;
               r_notes_valid <= 1'b1;
               for (int i = 0; i < NUM_PEAKS; i++) begin
                  r_tab_bin[i] <= '0;
                  r_tab_mag[i] <= '0;
               end
               r_count     <= '0;
               r_k         <= '0;
               r_bitmap    <= '0;
               r_bin_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= ST_COLLECT;
            end
         endcase
      end
   end

   assign bin_ready_out    = r_bin_ready;
   assign lookup_valid_out = r_lookup_valid;
   assign lookup_bin_out   = r_lookup_bin;
   assign notes_out        = r_notes;
   assign notes_valid_out  = r_notes_valid;
   assign busy_out         = r_busy;
   assign state_dbg_out    = r_state;

endmodule

// File: tb/tb_peak_note_scheduler.sv
// Directed bench for peak_note_scheduler: frames of bins with hand-picked
// magnitudes, an expected queue of lookup request bins and result notes,
// and checks on ordering, request stability, latency, reset and timeout.
module tb_peak_note_scheduler;

   localparam int BIN_W     = 10;
   localparam int MAG_W     = 16;
   localparam int NUM_PEAKS = 4;

   logic             clk_in = 1'b0;
   logic             rst_n_in = 1'b0;
   logic [MAG_W-1:0] threshold_in = 16'd100;
   logic             bin_valid_in = 1'b0;
   logic [BIN_W-1:0] bin_index_in = '0;
   logic [MAG_W-1:0] mag_in = '0;
   logic             bin_last_in = 1'b0;
   logic             bin_ready_out;
   logic [BIN_W-1:0] lookup_bin_out;
   logic             lookup_valid_out;
   logic             lookup_ready_in = 1'b0;
   logic             note_valid_in = 1'b0;
   logic [5:0]       note_index_in = '0;
   logic [63:0]      notes_out;
   logic             notes_valid_out;
   logic             busy_out;
   logic             timeout_err_out;
   logic [1:0]       state_dbg_out;

   int n_vec = 0;
   int n_err = 0;

   logic [BIN_W-1:0] exp_q [$];
   logic [5:0]       note_q [$];
   logic [MAG_W-1:0] mag_tab [256];

   peak_note_scheduler #(
      .BIN_W(BIN_W), .MAG_W(MAG_W), .NUM_PEAKS(NUM_PEAKS)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .threshold_in(threshold_in),
      .bin_valid_in(bin_valid_in), .bin_index_in(bin_index_in), .mag_in(mag_in),
      .bin_last_in(bin_last_in), .bin_ready_out(bin_ready_out),
      .lookup_bin_out(lookup_bin_out), .lookup_valid_out(lookup_valid_out),
      .lookup_ready_in(lookup_ready_in), .note_valid_in(note_valid_in),
      .note_index_in(note_index_in), .notes_out(notes_out),
      .notes_valid_out(notes_valid_out), .busy_out(busy_out),
      .timeout_err_out(timeout_err_out), .state_dbg_out(state_dbg_out)
   );

   // clock
   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   task automatic fill_mags(input logic [MAG_W-1:0] val);
      for (int i = 0; i < 256; i++) mag_tab[i] = val;
   endtask

   // Stream bins 0..nbins-1; optionally pulse note_valid_in alongside bin pulse_at.
   task automatic send_frame(input int nbins, input int pulse_at);
      bit not_ready = 1'b0;
      bit saw_lv    = 1'b0;
      for (int i = 0; i < nbins; i++) begin
         if (!bin_ready_out)   not_ready = 1'b1;
         if (lookup_valid_out) saw_lv    = 1'b1;
         bin_valid_in  = 1'b1;
         bin_index_in  = BIN_W'(i);
         mag_in        = mag_tab[i];
         bin_last_in   = (i == nbins - 1);
         note_valid_in = (i == pulse_at);
         note_index_in = 6'd0;
         tick;
      end
      bin_valid_in  = 1'b0;
      bin_last_in   = 1'b0;
      note_valid_in = 1'b0;
      check("ready_during_collect", {63'd0, not_ready}, 64'd0);
      check("no_lookup_during_collect", {63'd0, saw_lv}, 64'd0);
      check("busy_after_last", {63'd0, busy_out}, 64'd1);
      check("ready_drop_after_last", {63'd0, bin_ready_out}, 64'd0);
   endtask

   // Answer every queued request, then check the published bitmap and latency
   // (clock edges from the frame's last bin to the visible valid pulse).
   task automatic serve(input int rdy_delay);
      logic [63:0]      exp_bm = '0;
      logic [BIN_W-1:0] held;
      logic [5:0]       nt;
      int               cycles = 0;
      int               nreq = exp_q.size();
      int               t;
      bit               stray = 1'b0;
      while (exp_q.size() > 0) begin
         t = 0;
         while (!lookup_valid_out && t < 50) begin tick; cycles++; t++; end
         check("lookup_valid", {63'd0, lookup_valid_out}, 64'd1);
         if (!lookup_valid_out) begin
            exp_q.delete();
            note_q.delete();
            break;
         end
         check("lookup_bin", 64'(lookup_bin_out), 64'(exp_q.pop_front()));
         held = lookup_bin_out;
         for (int d = 0; d < rdy_delay; d++) begin
            tick; cycles++;
            check("hold_valid", {63'd0, lookup_valid_out}, 64'd1);
            check("hold_bin", 64'(lookup_bin_out), 64'(held));
         end
         lookup_ready_in = 1'b1;
         tick; cycles++;
         lookup_ready_in = 1'b0;
         check("valid_drop_after_accept", {63'd0, lookup_valid_out}, 64'd0);
         nt = note_q.pop_front();
         exp_bm = exp_bm | (64'd1 << nt);
         note_valid_in = 1'b1;
         note_index_in = nt;
         tick; cycles++;
         note_valid_in = 1'b0;
      end
      t = 0;
      while (!notes_valid_out && t < 50) begin
         if (lookup_valid_out) stray = 1'b1;
         tick; cycles++; t++;
      end
      check("no_stray_lookup", {63'd0, stray}, 64'd0);
      check("notes_valid", {63'd0, notes_valid_out}, 64'd1);
      check("notes_out", notes_out, exp_bm);
      check("latency", 64'(cycles), 64'(1 + nreq * (rdy_delay + 2)));
      tick;
      check("notes_valid_pulse", {63'd0, notes_valid_out}, 64'd0);
      check("notes_hold", notes_out, exp_bm);
      check("busy_after_publish", {63'd0, busy_out}, 64'd0);
      check("ready_after_publish", {63'd0, bin_ready_out}, 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, {63'd0, bin_ready_out}, 64'd0);
      check({tag, "_lvalid"}, {63'd0, lookup_valid_out}, 64'd0);
      check({tag, "_lbin"}, 64'(lookup_bin_out), 64'd0);
      check({tag, "_notes"}, notes_out, 64'd0);
      check({tag, "_nvalid"}, {63'd0, notes_valid_out}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy_out}, 64'd0);
      check({tag, "_terr"}, {63'd0, timeout_err_out}, 64'd0);
   endtask

   initial begin
      bit saw_pub;
      int t;

      // reset
      rst_n_in = 1'b0;
      tick; tick;
      check_all_zero("reset");
      rst_n_in = 1'b1;
      tick;
      check("ready_after_reset", {63'd0, bin_ready_out}, 64'd1);

      // single peak: bin 107 -> note 38, plus a stray note strobe during COLLECT
      fill_mags(16'd5);
      mag_tab[107] = 16'd900;
      exp_q.push_back(10'd107);
      note_q.push_back(6'd38);
      send_frame(256, 50);
      serve(0);

      // nothing above threshold (one bin exactly at threshold)
      fill_mags(16'd5);
      mag_tab[3]  = 16'd100;
      mag_tab[15] = 16'd99;
      send_frame(16, -1);
      serve(0);

      // six candidates, table keeps top four; tie 20/30 keeps arrival order
      fill_mags(16'd5);
      mag_tab[10] = 16'd900; mag_tab[20] = 16'd800; mag_tab[30] = 16'd800;
      mag_tab[40] = 16'd700; mag_tab[50] = 16'd600; mag_tab[60] = 16'd500;
      exp_q = '{10'd10, 10'd20, 10'd30, 10'd40};
      note_q = '{6'd1, 6'd2, 6'd3, 6'd1};
      send_frame(64, -1);
      serve(0);

      // out-of-order arrival, tie 8/11, drop of 200, slow ready, stray note strobe
      fill_mags(16'd5);
      mag_tab[5] = 16'd200; mag_tab[6] = 16'd300; mag_tab[7]  = 16'd250;
      mag_tab[8] = 16'd400; mag_tab[9] = 16'd150; mag_tab[11] = 16'd400;
      mag_tab[12] = 16'd100;
      exp_q = '{10'd8, 10'd11, 10'd6, 10'd7};
      note_q = '{6'd60, 6'd61, 6'd62, 6'd63};
      send_frame(16, 2);
      serve(7);

      // reset while waiting for a result
      fill_mags(16'd5);
      mag_tab[7] = 16'd900;
      send_frame(16, -1);
      check("abort_lookup_valid", {63'd0, lookup_valid_out}, 64'd1);
      check("abort_lookup_bin", 64'(lookup_bin_out), 64'd7);
      lookup_ready_in = 1'b1;
      tick;
      lookup_ready_in = 1'b0;
      rst_n_in = 1'b0;
      tick;
      rst_n_in = 1'b1;
      check_all_zero("midreset");
      saw_pub = 1'b0;
      tick;
      check("ready_after_midreset", {63'd0, bin_ready_out}, 64'd1);
      for (int i = 0; i < 5; i++) begin
         if (notes_valid_out) saw_pub = 1'b1;
         tick;
      end
      check("no_publish_after_reset", {63'd0, saw_pub}, 64'd0);

      // recovery frame: first and last bins are the peaks
      fill_mags(16'd5);
      mag_tab[0]   = 16'd1000;
      mag_tab[255] = 16'd999;
      exp_q = '{10'd0, 10'd255};
      note_q = '{6'd0, 6'd63};
      send_frame(256, -1);
      serve(0);

`ifdef NOTE_TIMEOUT_EN
      // slot 0 never answered: skipped after 64 WAIT cycles, slot 1 still published
      fill_mags(16'd5);
      mag_tab[3] = 16'd500;
      mag_tab[9] = 16'd400;
      send_frame(16, -1);
      check("to_bin0", 64'(lookup_bin_out), 64'd3);
      lookup_ready_in = 1'b1;
      tick;
      lookup_ready_in = 1'b0;
      t = 0;
      while (!lookup_valid_out && t < 100) begin tick; t++; end
      check("to_wait_cycles", 64'(t), 64'd64);
      check("to_err_set", {63'd0, timeout_err_out}, 64'd1);
      exp_q = '{10'd9};
      note_q = '{6'd17};
      serve(0);
      check("to_err_sticky", {63'd0, timeout_err_out}, 64'd1);
`else
      t = 0;
      check("timeout_err_idle", {63'd0, timeout_err_out}, 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
